// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared encodings for the MEM-stage data-memory access unit:
//   - access-size operation codes (MEM_EXT_*), RV32I funct3 layout
//   - access FSM state encoding (MEM_ACC_*)
//   - access_size(): collapses the signed/unsigned op variants to B/H/W
// -----------------------------------------------------------------------------
package mem_access_pkg;

  localparam int MEM_EXT_OP_WIDTH = 3;

  // funct3 layout: bit 2 = unsigned, bits 1:0 = size
  localparam logic [MEM_EXT_OP_WIDTH-1:0] MEM_EXT_B  = 3'b000;
  localparam logic [MEM_EXT_OP_WIDTH-1:0] MEM_EXT_H  = 3'b001;
  localparam logic [MEM_EXT_OP_WIDTH-1:0] MEM_EXT_W  = 3'b010;
  localparam logic [MEM_EXT_OP_WIDTH-1:0] MEM_EXT_BU = 3'b100;
  localparam logic [MEM_EXT_OP_WIDTH-1:0] MEM_EXT_HU = 3'b101;

  localparam int MEM_ACC_ST_WIDTH = 2;

  typedef enum logic [MEM_ACC_ST_WIDTH-1:0] {
    MEM_ACC_IDLE = 2'd0,
    MEM_ACC_BUSY = 2'd1,
    MEM_ACC_DONE = 2'd2
  } mem_acc_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } acc_size_e;

  // Unknown op codes are treated as word accesses.
  function automatic acc_size_e access_size(input logic [MEM_EXT_OP_WIDTH-1:0] op);
    acc_size_e sz;
    case (op)
      MEM_EXT_B, MEM_EXT_BU: sz = SIZE_B;
      MEM_EXT_H, MEM_EXT_HU: sz = SIZE_H;
      default:               sz = SIZE_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// -----------------------------------------------------------------------------
// mem_lane
// Combinational byte-lane steering for a load/store request.
// Optional feature macro: MEM_ACCESS_MISALIGN_EXC_EN
//   defined   : misalign = 1 for H/HU with addr[0]=1 or W with addr[1:0]!=0
//   undefined : misalign = 0; offending low bits are simply ignored, which
//               the H/W lane and offset formulas below already do.
// Ports:
//   op      in  access size (MEM_EXT_*)
//   addr_lo in  address bits 1:0
//   wdata   in  right-justified store data
//   be      out byte enables
//   lanes   out store data replicated across the active lanes
//   offset  out byte offset used to right-justify load data
//   misalign out access is misaligned (only when the feature is enabled)
// -----------------------------------------------------------------------------
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [MEM_EXT_OP_WIDTH-1:0] op,
  input  logic [1:0]                  addr_lo,
  input  logic [31:0]                 wdata,
  output logic [3:0]                  be,
  output logic [31:0]                 lanes,
  output logic [1:0]                  offset,
  output logic                        misalign
);

  always_comb begin
    be     = 4'b1111;
    lanes  = wdata;
    offset = 2'b00;
    case (access_size(op))
      SIZE_B: begin
        be     = 4'b0001 << addr_lo;
        lanes  = {4{wdata[7:0]}};
        offset = addr_lo;
      end
      SIZE_H: begin
        be     = 4'b0011 << {addr_lo[1], 1'b0};
        lanes  = {2{wdata[15:0]}};
        offset = {addr_lo[1], 1'b0};
      end
      default: begin
        be     = 4'b1111;
        lanes  = wdata;
        offset = 2'b00;
      end
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  always_comb begin
    misalign = 1'b0;
    case (access_size(op))
      SIZE_H:  misalign = addr_lo[0];
      SIZE_W:  misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// MEM-stage data-memory access unit. Converts a load/store request into one
// bus transaction (valid/ready handshake) and stalls the pipeline until it
// completes. Load data is right-justified and zero-padded above the access
// width; sign/zero extension happens downstream.
// Optional feature macro: MEM_ACCESS_MISALIGN_EXC_EN (misaligned H/W raise
// exc_misalign without touching the bus; otherwise the low bits are ignored).
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles without a response before faulting (1..255)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/we/op/addr/wdata  request from the MEM stage
//   flush                    kill the current MEM-stage instruction
//   stall                    freeze the pipeline
//   done                     one-cycle completion pulse
//   rdata                    lane-shifted load data
//   exc_misalign, exc_fault  exception pulses aligned with done
//   bus_req/we/addr/be/wdata bus request side (registered)
//   bus_ready/rdata/err      bus response side
// -----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        req_we,
  input  logic [MEM_EXT_OP_WIDTH-1:0] req_op,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic                        flush,
  output logic                        stall,
  output logic                        done,
  output logic [31:0]                 rdata,
  output logic                        exc_misalign,
  output logic                        exc_fault,
  output logic                        bus_req,
  output logic                        bus_we,
  output logic [31:0]                 bus_addr,
  output logic [3:0]                  bus_be,
  output logic [31:0]                 bus_wdata,
  input  logic                        bus_ready,
  input  logic [31:0]                 bus_rdata,
  input  logic                        bus_err
);

  // Counter value seen in the last permitted BUSY cycle (counter is 0 in the
  // first BUSY cycle).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_acc_state_e state, state_next;

  logic [3:0]                  lane_be;
  logic [31:0]                 lane_wdata;
  logic [1:0]                  lane_off;
  logic                        lane_mis;

  logic [MEM_EXT_OP_WIDTH-1:0] op_p1;
  logic [1:0]                  off_p1;
  logic [7:0]                  cnt;
  logic                        killed;
  logic                        fault_flag;
  logic                        mis_flag;

  logic                        start;
  logic                        start_mis;
  logic                        finish;
  logic                        timeout;
  logic                        fault_now;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Right-justify the addressed bytes and clear everything above the size.
  function automatic logic [31:0] load_shape(input logic [31:0]                 word,
                                             input logic [1:0]                  off,
                                             input logic [MEM_EXT_OP_WIDTH-1:0] op);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (access_size(op))
      SIZE_B:  r = {24'h000000, s[7:0]};
      SIZE_H:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  mem_lane u_lane (
    .op       (req_op),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .be       (lane_be),
    .lanes    (lane_wdata),
    .offset   (lane_off),
    .misalign (lane_mis)
  );

  assign stall     = req_valid & (state != MEM_ACC_DONE);
  assign timeout   = (cnt >= CNT_LAST);
  // A response in the timeout cycle wins; bus_err always faults.
  assign fault_now = bus_err | (timeout & ~bus_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MEM_ACC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    start        = 1'b0;
    start_mis    = 1'b0;
    finish       = 1'b0;
    done         = 1'b0;
    exc_misalign = 1'b0;
    exc_fault    = 1'b0;
    case (state)
      MEM_ACC_IDLE: begin
        if (req_valid && !flush) begin
          if (lane_mis) begin
            state_next = MEM_ACC_DONE;
            start_mis  = 1'b1;
          end else begin
            state_next = MEM_ACC_BUSY;
            start      = 1'b1;
          end
        end
      end
      MEM_ACC_BUSY: begin
        if (bus_ready || bus_err || timeout) begin
          state_next = MEM_ACC_DONE;
          finish     = 1'b1;
        end
      end
      MEM_ACC_DONE: begin
        state_next   = MEM_ACC_IDLE;
        done         = ~killed;
        exc_misalign = mis_flag & ~killed;
        exc_fault    = fault_flag & ~killed;
      end
      default: state_next = MEM_ACC_IDLE;
    endcase
  end

  // Control flags and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req    <= 1'b0;
      cnt        <= 8'd0;
      killed     <= 1'b0;
      fault_flag <= 1'b0;
      mis_flag   <= 1'b0;
    end else begin
      if (start) begin
        bus_req    <= 1'b1;
        cnt        <= 8'd0;
        killed     <= 1'b0;
        fault_flag <= 1'b0;
        mis_flag   <= 1'b0;
      end
      if (start_mis) begin
        killed     <= 1'b0;
        fault_flag <= 1'b0;
        mis_flag   <= 1'b1;
      end
      if (state == MEM_ACC_BUSY) begin
        cnt <= sat_inc(cnt);
        // The transaction still completes; only the completion report dies.
        if (flush) begin
          killed <= 1'b1;
        end
      end
      if (finish) begin
        bus_req    <= 1'b0;
        fault_flag <= fault_now;
      end
    end
  end

  // Request capture (held stable while bus_req is high) and load data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      op_p1     <= MEM_EXT_B;
      off_p1    <= 2'b00;
      rdata     <= 32'h0;
    end else begin
      if (start) begin
        bus_we    <= req_we;
        bus_addr  <= {req_addr[31:2], 2'b00};
        bus_be    <= lane_be;
        bus_wdata <= lane_wdata;
        op_p1     <= req_op;
        off_p1    <= lane_off;
      end
      if (finish) begin
        rdata <= load_shape(bus_rdata, off_p1, op_p1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int T = 4;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, flush;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, exc_misalign, exc_fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ready, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .done(done), .rdata(rdata),
    .exc_misalign(exc_misalign), .exc_fault(exc_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    int          end_cyc;
    logic        done;
    logic        mis;
    logic        fault;
    int          req_cnt;
    int          unstable;
    int          extra_done;
    logic        done_after;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
  } obs_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".bus_req"}, 32'(bus_req), 0);
    chk({tag, ".bus_we"}, 32'(bus_we), 0);
    chk({tag, ".bus_addr"}, bus_addr, 0);
    chk({tag, ".bus_be"}, 32'(bus_be), 0);
    chk({tag, ".bus_wdata"}, bus_wdata, 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".exc_mis"}, 32'(exc_misalign), 0);
    chk({tag, ".exc_fault"}, 32'(exc_fault), 0);
    chk({tag, ".stall"}, 32'(stall), 0);
  endtask

  // Behavioural reference: outcome of one access from the access rules alone.
  // ready_at: BUSY cycle (1-based) from which the response is presented, 0 = never.
  function automatic obs_t model(input logic we, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] brd, input int ready_at,
                                 input logic rr, input logic re, input int flush_at);
    obs_t e;
    int size, off, n, be_i;
    bit mis, responds, killed;
    logic [63:0] mask;
    e = '{default: 0};
    size = (op == MEM_EXT_B || op == MEM_EXT_BU) ? 1 :
           (op == MEM_EXT_H || op == MEM_EXT_HU) ? 2 : 4;
    off = int'(addr[1:0]);
    mis = (off % size) != 0;
    off = off - (off % size);
    if (MIS_EN && mis) begin
      e.end_cyc = 1;
      e.done    = 1'b1;
      e.mis     = 1'b1;
      return e;
    end
    responds  = (ready_at >= 1) && (ready_at <= T) && (rr || re);
    n         = responds ? ready_at : T;
    killed    = (flush_at >= 1) && (flush_at <= n);
    e.end_cyc = n + 1;
    e.done    = !killed;
    e.fault   = (responds ? re : 1'b1) && !killed;
    e.req_cnt = n;
    e.addr    = addr & 32'hFFFF_FFFC;
    e.we      = we;
    be_i      = ((1 << size) - 1) << off;
    e.be      = be_i[3:0];
    e.wdata   = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    mask      = (64'd1 << (8 * size)) - 64'd1;
    e.rdata   = 32'(({32'h0, brd} >> (8 * off)) & mask);
    return e;
  endfunction

  // Drives one access starting just after a rising edge; cycle 0 is the IDLE
  // cycle in which req_valid is first seen. Ends when stall drops.
  task automatic run(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] brd,
                     input int ready_at, input logic rr, input logic re,
                     input int flush_at, input logic early, output obs_t o);
    bit seen;
    o = '{default: 0};
    o.end_cyc = -1;
    seen = 0;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr;
    req_wdata = wdata; bus_rdata = brd;
    for (int c = 0; c < 200; c++) begin
      bus_ready = (ready_at > 0 && c >= ready_at) ? rr : (c == 0 && early);
      bus_err   = (ready_at > 0 && c >= ready_at) ? re : 1'b0;
      flush     = (flush_at > 0 && c == flush_at);
      @(negedge clk);
      if (bus_req) begin
        o.req_cnt++;
        if (!seen) begin
          seen = 1;
          o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata; o.we = bus_we;
        end else if (bus_addr !== o.addr || bus_be !== o.be ||
                     bus_wdata !== o.wdata || bus_we !== o.we) begin
          o.unstable++;
        end
      end
      if (!stall) begin
        o.end_cyc = c; o.done = done; o.mis = exc_misalign;
        o.fault = exc_fault; o.rdata = rdata;
        break;
      end
      if (done) o.extra_done++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b0; bus_err = 1'b0; flush = 1'b0;
    @(negedge clk);
    o.done_after = done;
    @(posedge clk); #1;
  endtask

  task automatic cmp(input string name, input obs_t o, input obs_t e);
    chk({name, ".end_cyc"}, o.end_cyc, e.end_cyc);
    chk({name, ".done"}, 32'(o.done), 32'(e.done));
    chk({name, ".exc_mis"}, 32'(o.mis), 32'(e.mis));
    chk({name, ".exc_fault"}, 32'(o.fault), 32'(e.fault));
    chk({name, ".req_cycles"}, o.req_cnt, e.req_cnt);
    chk({name, ".unstable"}, o.unstable, 0);
    chk({name, ".early_done"}, o.extra_done, 0);
    chk({name, ".done_after"}, 32'(o.done_after), 0);
    if (e.req_cnt > 0) begin
      chk({name, ".bus_addr"}, o.addr, e.addr);
      chk({name, ".bus_be"}, 32'(o.be), 32'(e.be));
      chk({name, ".bus_wdata"}, o.wdata, e.wdata);
      chk({name, ".bus_we"}, 32'(o.we), 32'(e.we));
      chk({name, ".rdata"}, o.rdata, e.rdata);
    end
  endtask

  logic [2:0] ld_ops[5];
  logic [2:0] st_ops[3];

  initial begin
    obs_t o, e;
    int cnt_done;
    ld_ops = '{MEM_EXT_B, MEM_EXT_BU, MEM_EXT_H, MEM_EXT_HU, MEM_EXT_W};
    st_ops = '{MEM_EXT_B, MEM_EXT_H, MEM_EXT_W};

    rst = 1'b1; req_valid = 0; req_we = 0; req_op = MEM_EXT_W; req_addr = 0;
    req_wdata = 0; flush = 0; bus_ready = 0; bus_err = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // SW 0xDEADBEEF to 0x100, zero-wait memory
    run(1'b1, MEM_EXT_W, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b1, 1'b0, 0, 1'b0, o);
    chk("sw.be", 32'(o.be), 32'hF);
    chk("sw.wdata", o.wdata, 32'hDEADBEEF);
    chk("sw.done_cycle", o.end_cyc, 2);
    chk("sw.done", 32'(o.done), 1);
    cmp("sw", o, model(1'b1, MEM_EXT_W, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b1, 1'b0, 0));

    // LB from 0x103, 3 wait cycles (response lands in the timeout cycle)
    run(1'b0, MEM_EXT_B, 32'h103, 32'h0, 32'h80FF_1234, 4, 1'b1, 1'b0, 0, 1'b1, o);
    chk("lb.be", 32'(o.be), 32'h8);
    chk("lb.rdata", o.rdata, 32'h0000_0080);
    chk("lb.done_cycle", o.end_cyc, 5);
    chk("lb.no_fault", 32'(o.fault), 0);
    cmp("lb", o, model(1'b0, MEM_EXT_B, 32'h103, 32'h0, 32'h80FF_1234, 4, 1'b1, 1'b0, 0));

    // SH of 0xABCD to 0x202
    run(1'b1, MEM_EXT_H, 32'h202, 32'h0000_ABCD, 32'h0, 2, 1'b1, 1'b0, 0, 1'b0, o);
    chk("sh.be", 32'(o.be), 32'hC);
    chk("sh.wdata", o.wdata, 32'hABCD_ABCD);
    chk("sh.addr", o.addr, 32'h200);

    // LW from 0x102
    run(1'b0, MEM_EXT_W, 32'h102, 32'h0, 32'h1122_3344, 1, 1'b1, 1'b0, 0, 1'b0, o);
    chk("lw_mis.req_cycles", o.req_cnt, MIS_EN ? 0 : 1);
    chk("lw_mis.exc_mis", 32'(o.mis), 32'(MIS_EN));
    chk("lw_mis.done_cycle", o.end_cyc, MIS_EN ? 1 : 2);
    chk("lw_mis.addr", o.addr, MIS_EN ? 32'h0 : 32'h100);
    cmp("lw_mis", o, model(1'b0, MEM_EXT_W, 32'h102, 32'h0, 32'h1122_3344, 1, 1'b1, 1'b0, 0));

    // No response at all: timeout after T BUSY cycles
    run(1'b0, MEM_EXT_W, 32'h300, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0, 0, 1'b0, o);
    chk("tmo.fault", 32'(o.fault), 1);
    chk("tmo.done", 32'(o.done), 1);
    chk("tmo.req_cycles", o.req_cnt, T);
    chk("tmo.done_cycle", o.end_cyc, T + 1);

    // bus_err together with bus_ready on a load
    run(1'b0, MEM_EXT_H, 32'h104, 32'h0, 32'hCAFE_8001, 2, 1'b1, 1'b1, 0, 1'b0, o);
    chk("err.fault", 32'(o.fault), 1);
    chk("err.rdata", o.rdata, 32'h0000_8001);

    // Flush in the 2nd BUSY cycle, ready in the 3rd
    run(1'b0, MEM_EXT_W, 32'h400, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 1'b0, 2, 1'b0, o);
    chk("flush.req_cycles", o.req_cnt, 3);
    chk("flush.done", 32'(o.done), 0);
    chk("flush.exc", 32'({o.fault, o.mis}), 0);
    cmp("flush", o, model(1'b0, MEM_EXT_W, 32'h400, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 1'b0, 2));

    // Flush while IDLE: no request issued
    req_valid = 1'b1; req_we = 1'b0; req_op = MEM_EXT_W; req_addr = 32'h600; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush.stall", 32'(stall), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush.bus_req", 32'(bus_req), 0);
    @(posedge clk); #1;

    // Reset pulsed mid-BUSY
    req_valid = 1'b1; req_we = 1'b1; req_op = MEM_EXT_W; req_addr = 32'h500;
    req_wdata = 32'h1234_5678; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy.bus_req_before", 32'(bus_req), 1);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_busy");
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || bus_req) cnt_done++;
    end
    chk("rst_busy.quiet_after", cnt_done, 0);
    @(posedge clk); #1;

    // Randomized accesses against the reference model
    for (int k = 0; k < 40; k++) begin
      logic        we, rr, re, early;
      logic [2:0]  op;
      logic [31:0] addr, wdata, brd;
      int          ready_at, flush_at;
      we       = 1'($urandom_range(0, 1));
      op       = we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
      addr     = $urandom();
      wdata    = $urandom();
      brd      = $urandom();
      ready_at = $urandom_range(1, 6);
      rr       = ($urandom_range(0, 7) != 0);
      re       = ($urandom_range(0, 7) == 0);
      flush_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      early    = 1'($urandom_range(0, 1));
      run(we, op, addr, wdata, brd, ready_at, rr, re, flush_at, early, o);
      e = model(we, op, addr, wdata, brd, ready_at, rr, re, flush_at);
      cmp($sformatf("rnd%0d", k), o, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
